// File: rtl/kgp_risc_pkg.sv
// ---------------------------------------------------------------------------
// kgp_risc_pkg
// Shared constants and types for the writeback register file.
//   DATA_W_DEF / ADDR_W_DEF : default data width and address width
//   CNT_W                   : width of the accepted-write counter
//   RA_ADDR                 : link-register address
//   wb_state_e              : state of the writeback holding stage
// ---------------------------------------------------------------------------
package kgp_risc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W      = 16;

    localparam logic [4:0] RA_ADDR = 5'd31;

    // The holding stage is either empty or carries one write awaiting commit.
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_PEND = 1'b1
    } wb_state_e;

endpackage

// File: rtl/rf_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One combinational read port with bypass from the writeback holding register.
// Ports:
//   i_addr      : read address
//   i_pend      : holding register carries a write awaiting commit
//   i_hold_addr : address held in the holding register
//   i_hold_data : data held in the holding register
//   i_arr_data  : array entry already selected by i_addr
//   o_data      : read result
// Parameter ZERO_LOCK forces reads of address 0 to return zero.
// ---------------------------------------------------------------------------
module rf_read_port #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_LOCK = 1'b0
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_pend,
    input  logic [ADDR_W-1:0] i_hold_addr,
    input  logic [DATA_W-1:0] i_hold_data,
    input  logic [DATA_W-1:0] i_arr_data,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_arr_data;
        if (ZERO_LOCK && (i_addr == '0)) begin
            o_data = '0;
        end else if (i_pend && (i_addr == i_hold_addr)) begin
            // The held write is younger than anything in the array.
            o_data = i_hold_data;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
// Register file with a two-stage writeback: a write is captured into a
// holding register on one edge and committed to the array on the next.
// Reads are combinational and bypass the holding register, so a write
// presented in cycle N is visible from cycle N+1.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   RegWrite : write request for the current cycle
//   wrA/wrD  : write address / data
//   rsA/rtA  : read addresses
//   rsD/rtD  : read data
//   pend     : a captured write awaits commit (holding-stage state)
//   wr_count : count of accepted writes, wraps at 16 bits
//
// Build option: define REGFILE_ZERO_LOCK_EN to make register 0 read as zero
// and to drop (neither capture nor count) writes to it.
// ---------------------------------------------------------------------------
module reg_file_wb
    import kgp_risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] wrA,
    input  logic [DATA_W-1:0] wrD,
    input  logic [ADDR_W-1:0] rsA,
    input  logic [ADDR_W-1:0] rtA,
    output logic [DATA_W-1:0] rsD,
    output logic [DATA_W-1:0] rtD,
    output logic              pend,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_ZERO_LOCK_EN
    localparam bit ZERO_LOCK = 1'b1;
`else
    localparam bit ZERO_LOCK = 1'b0;
`endif

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;
    logic              w_commit;
    logic              w_accept;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_rs_arr;
    logic [DATA_W-1:0] w_rt_arr;

    // A write to the locked register 0 is simply not accepted.
    assign w_accept = RegWrite && !(ZERO_LOCK && (wrA == '0));

    // ------------------------------------------------------------------
    // Holding-stage FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending entry always commits on the next edge; a new capture on that
    // same edge refills the stage, so back-to-back writes never stall.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = WB_PEND;
                end
            end
            WB_PEND: begin
                w_commit = 1'b1;
                if (!w_accept) begin
                    w_state_nxt = WB_IDLE;
                end
            end
            default: begin
                w_state_nxt = WB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else if (w_accept) begin
            r_hold_addr <= wrA;
            r_hold_data <= wrD;
        end
    end

    // ------------------------------------------------------------------
    // Storage array; a write pending at reset is dropped with the stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_hold_addr] <= r_hold_data;
        end
    end

    // ------------------------------------------------------------------
    // Accepted-write counter, wraps naturally
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign pend     = (r_state == WB_PEND);
    assign wr_count = r_count;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    assign w_rs_arr = r_mem[rsA];
    assign w_rt_arr = r_mem[rtA];

    rf_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .ZERO_LOCK (ZERO_LOCK)
    ) u_rs_port (
        .i_addr      (rsA),
        .i_pend      (pend),
        .i_hold_addr (r_hold_addr),
        .i_hold_data (r_hold_data),
        .i_arr_data  (w_rs_arr),
        .o_data      (rsD)
    );

    rf_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .ZERO_LOCK (ZERO_LOCK)
    ) u_rt_port (
        .i_addr      (rtA),
        .i_pend      (pend),
        .i_hold_addr (r_hold_addr),
        .i_hold_data (r_hold_data),
        .i_arr_data  (w_rt_arr),
        .o_data      (rtD)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wb
// Self-checking bench for reg_file_wb. The reference model treats the
// register file as a plain array whose content changes at the write edge
// (what the reader observes thanks to the bypass), a pending flag meaning
// "the last edge accepted a write", and a counter of accepted writes.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_reg_file_wb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef REGFILE_ZERO_LOCK_EN
    localparam bit ZL = 1'b1;
`else
    localparam bit ZL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite;
    logic [AW-1:0] wrA;
    logic [DW-1:0] wrD;
    logic [AW-1:0] rsA;
    logic [AW-1:0] rtA;
    logic [DW-1:0] rsD;
    logic [DW-1:0] rtD;
    logic          pend;
    logic [15:0]   wr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_pend;
    logic [15:0]   m_cnt;

    reg_file_wb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .wrA      (wrA),
        .wrD      (wrD),
        .rsA      (rsA),
        .rtA      (rtA),
        .rsD      (rsD),
        .rtD      (rtD),
        .pend     (pend),
        .wr_count (wr_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_pend = 1'b0;
        m_cnt  = 16'h0000;
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (ZL && (a == '0)) return '0;
        return m_mem[a];
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt);
        @(negedge clk);
        rst      = r;
        RegWrite = we;
        wrA      = wa;
        wrD      = wd;
        rsA      = rs;
        rtA      = rt;
        if (r) model_reset();
        #1;
    endtask

    // Advance through the rising edge and apply the write rules to the model.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (RegWrite && !(ZL && (wrA == '0))) begin
            m_mem[wrA] = wrD;
            m_cnt      = m_cnt + 16'd1;
            m_pend     = 1'b1;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        step();
        step();
        drive(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; RegWrite = 1'b0; wrA = '0; wrD = '0; rsA = '0; rtA = '0;
        model_reset();
        // Writes requested while reset is held must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'($urandom), AW'(i), AW'(DEPTH - 1 - i));
            checks++;
            if (rsD !== '0 || rtD !== '0 || pend !== 1'b0 || wr_count !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold addr=%0d rsD=%h rtD=%h pend=%b cnt=%h exp all zero",
                         i, rsD, rtD, pend, wr_count);
            end
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
            checks++;
            if (rsD !== '0 || rtD !== '0 || pend !== 1'b0 || wr_count !== 16'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d rsD=%h rtD=%h pend=%b cnt=%h exp all zero",
                         i, rsD, rtD, pend, wr_count);
            end
            step();
        end
    endtask

    task automatic test_single_write();
        logic [DW-1:0] exp_rs [3];
        logic          exp_p  [3];
        exp_rs[0] = 32'h0;        exp_p[0] = 1'b0;
        exp_rs[1] = 32'hDEADBEEF; exp_p[1] = 1'b1;
        exp_rs[2] = 32'hDEADBEEF; exp_p[2] = 1'b0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
            else        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
            checks++;
            if (rsD !== exp_rs[c] || rtD !== exp_rs[c] || pend !== exp_p[c]) begin
                errors++;
                $display("FAIL single_write cyc=%0d rsD=%h rtD=%h pend=%b exp=%h/%b",
                         c, rsD, rtD, pend, exp_rs[c], exp_p[c]);
            end
            step();
        end
        checks++;
        if (wr_count !== 16'd1) begin
            errors++;
            $display("FAIL single_count got=%h exp=0001", wr_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd7);
        checks++;
        if (rtD !== 32'h0) begin
            errors++;
            $display("FAIL b2b_cycN got=%h exp=0", rtD);
        end
        step();
        drive(1'b0, 1'b1, 5'd7, 32'h22, 5'd0, 5'd7);
        checks++;
        if (rtD !== 32'h11 || pend !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got=%h pend=%b exp=11/1", rtD, pend);
        end
        step();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
            checks++;
            if (rtD !== 32'h22 || wr_count !== 16'd2 || pend !== (c == 0)) begin
                errors++;
                $display("FAIL b2b_later cyc=%0d rtD=%h cnt=%h pend=%b exp=22/0002/%b",
                         c, rtD, wr_count, pend, (c == 0));
            end
            step();
        end
    endtask

    task automatic test_reset_discard();
        do_reset();
        drive(1'b0, 1'b1, 5'd3, 32'hABCD, 5'd3, 5'd3);
        step();
        // Reset lands while the write sits in the holding stage.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (rsD !== 32'h0 || pend !== 1'b0) begin
            errors++;
            $display("FAIL discard_async rsD=%h pend=%b exp=0/0", rsD, pend);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
            checks++;
            if (rsD !== 32'h0 || rtD !== 32'h0 || wr_count !== 16'h0) begin
                errors++;
                $display("FAIL discard_after cyc=%0d rsD=%h rtD=%h cnt=%h exp=0/0/0",
                         c, rsD, rtD, wr_count);
            end
            step();
        end
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] exp_d;
        logic          exp_p;
        logic [15:0]   exp_c;
        exp_d = ZL ? 32'h0 : 32'hFFFFFFFF;
        exp_p = ZL ? 1'b0 : 1'b1;
        exp_c = ZL ? 16'd0 : 16'd1;
        do_reset();
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd1, 32'h0, 5'd0, 5'd0);
        checks++;
        if (rsD !== exp_d || pend !== exp_p || wr_count !== exp_c) begin
            errors++;
            $display("FAIL zero_reg_bypass rsD=%h pend=%b cnt=%h exp=%h/%b/%h",
                     rsD, pend, wr_count, exp_d, exp_p, exp_c);
        end
        step();
        drive(1'b0, 1'b0, 5'd1, 32'h0, 5'd0, 5'd0);
        checks++;
        if (rsD !== exp_d || rtD !== exp_d || pend !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_array rsD=%h rtD=%h pend=%b exp=%h/%h/0",
                     rsD, rtD, pend, exp_d, exp_d);
        end
        step();
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        logic          r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 59) == 0);
            wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            drive(r, ($urandom_range(0, 2) != 0), wa, DW'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 3)),
                  AW'($urandom));
            checks++;
            if (rsD !== m_read(rsA) || rtD !== m_read(rtA) ||
                pend !== m_pend || wr_count !== m_cnt) begin
                errors++;
                $display("FAIL random cyc=%0d rs[%0d]=%h exp=%h rt[%0d]=%h exp=%h pend=%b exp=%b cnt=%h exp=%h",
                         c, rsA, rsD, m_read(rsA), rtA, rtD, m_read(rtA),
                         pend, m_pend, wr_count, m_cnt);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] last_d;
        last_d = '0;
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            last_d = DW'($urandom);
            drive(1'b0, 1'b1, 5'd31, last_d, 5'd31, 5'd31);
            if (i == 65535) begin
                checks++;
                if (wr_count !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL wrap_pre got=%h exp=FFFF", wr_count);
                end
            end
            checks++;
            if (rsD !== m_read(5'd31)) begin
                errors++;
                $display("FAIL wrap_data i=%0d got=%h exp=%h", i, rsD, m_read(5'd31));
            end
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        checks++;
        if (wr_count !== 16'h0000 || wr_count !== m_cnt || rsD !== last_d) begin
            errors++;
            $display("FAIL wrap_final cnt=%h rsD=%h exp=0000/%h", wr_count, rsD, last_d);
        end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_reset_discard();
        test_zero_reg();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
